// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised RAM with combinational reads plus a
// memory-mapped 32-bit timer (COUNT/COMPARE/CTRL) at the top of the address space.
module data_mem_responder #(
    parameter int                        MEM_ADDR_WIDTH = 10,
    parameter int                        DATA_WIDTH     = 32,
    parameter int                        TRANSFER_WIDTH = 4,
    parameter logic [MEM_ADDR_WIDTH-1:0] PERIPH_BASE    = 10'h3F0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we_mem_data_i,
    input  logic [MEM_ADDR_WIDTH-1:0] addr_mem_data_i,
    input  logic [DATA_WIDTH-1:0]     val_mem_data_write_i,
    input  logic [TRANSFER_WIDTH-1:0] write_transfer_mem_data_i,
    output logic [DATA_WIDTH-1:0]     val_mem_data_read_o,
    output logic                      irq_timer_o
);

    localparam int WORD_AW = MEM_ADDR_WIDTH - 2;
    localparam int DEPTH   = 1 << WORD_AW;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [WORD_AW-1:0]    word_idx;
    logic                  periph_sel;
    logic [1:0]            reg_off;
    logic                  ram_we;
    logic                  count_wr, compare_wr, ctrl_wr;
    logic                  match_now, match_clr;

    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] compare_q, compare_d;
    logic                  en_q, en_d;
    logic                  autoreload_q, autoreload_d;
    logic                  ie_q, ie_d;
    logic                  match_q, match_d;
    logic                  irq_q, irq_d;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0]     old_val,
        input logic [DATA_WIDTH-1:0]     new_val,
        input logic [TRANSFER_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < TRANSFER_WIDTH; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        word_idx   = addr_mem_data_i[MEM_ADDR_WIDTH-1:2];
        periph_sel = (addr_mem_data_i >= PERIPH_BASE);
        reg_off    = addr_mem_data_i[3:2];
        ram_we     = we_mem_data_i && !periph_sel;
        count_wr   = we_mem_data_i && periph_sel && (reg_off == 2'd0);
        compare_wr = we_mem_data_i && periph_sel && (reg_off == 2'd1);
        ctrl_wr    = we_mem_data_i && periph_sel && (reg_off == 2'd2);
    end

    // Next-state for the timer; a COUNT write always beats reload/increment.
    always_comb begin
        match_now = en_q && (count_q == compare_q);

        count_d = count_q;
        if (count_wr) begin
            count_d = merge_lanes(count_q, val_mem_data_write_i, write_transfer_mem_data_i);
        end else if (match_now && autoreload_q) begin
            count_d = '0;
        end else if (en_q) begin
            count_d = count_q + DATA_WIDTH'(1);
        end

        compare_d = compare_q;
        if (compare_wr) begin
            compare_d = merge_lanes(compare_q, val_mem_data_write_i, write_transfer_mem_data_i);
        end

        en_d         = en_q;
        autoreload_d = autoreload_q;
        ie_d         = ie_q;
        if (ctrl_wr && write_transfer_mem_data_i[0]) begin
            en_d         = val_mem_data_write_i[0];
            autoreload_d = val_mem_data_write_i[1];
            ie_d         = val_mem_data_write_i[2];
        end

        // Setting takes priority over a simultaneous write-1-to-clear.
        match_clr = ctrl_wr && write_transfer_mem_data_i[1] && val_mem_data_write_i[8];
        match_d   = match_now || (match_q && !match_clr);
        irq_d     = match_d && ie_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            compare_q    <= '1;
            en_q         <= 1'b0;
            autoreload_q <= 1'b0;
            ie_q         <= 1'b0;
            match_q      <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            compare_q    <= compare_d;
            en_q         <= en_d;
            autoreload_q <= autoreload_d;
            ie_q         <= ie_d;
            match_q      <= match_d;
            irq_q        <= irq_d;
        end
    end

    // RAM is intentionally unreset; a reset cycle only suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            for (int i = 0; i < TRANSFER_WIDTH; i++) begin
                if (write_transfer_mem_data_i[i]) begin
                    mem_q[word_idx][8*i +: 8] <= val_mem_data_write_i[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        val_mem_data_read_o = '0;
        if (periph_sel) begin
            case (reg_off)
                2'd0: val_mem_data_read_o = count_q;
                2'd1: val_mem_data_read_o = compare_q;
                2'd2: begin
                    val_mem_data_read_o[0] = en_q;
                    val_mem_data_read_o[1] = autoreload_q;
                    val_mem_data_read_o[2] = ie_q;
                    val_mem_data_read_o[8] = match_q;
                end
                default: val_mem_data_read_o = '0;
            endcase
        end else begin
            val_mem_data_read_o = mem_q[word_idx];
        end
    end

    assign irq_timer_o = irq_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus queues expected read data / irq,
// a negedge monitor pops and compares against the DUT outputs.
module tb_data_mem_responder;

    localparam logic [9:0] A_CNT = 10'h3F0;
    localparam logic [9:0] A_CMP = 10'h3F4;
    localparam logic [9:0] A_CTL = 10'h3F8;
    localparam logic [9:0] A_RSV = 10'h3FC;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        irq;

    typedef struct {
        string       nm;
        logic        chk_d;
        logic [31:0] exp_d;
        logic        chk_i;
        logic        exp_i;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    logic mon_en = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    data_mem_responder dut (
        .clk                       (clk),
        .rst                       (rst),
        .we_mem_data_i             (we),
        .addr_mem_data_i           (addr),
        .val_mem_data_write_i      (wdata),
        .write_transfer_mem_data_i (strb),
        .val_mem_data_read_o       (rdata),
        .irq_timer_o               (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow: monitor saw a check with no expectation queued");
            end else begin
                e = sb_q.pop_front();
                if (e.chk_d) begin
                    n_cmp++;
                    if (rdata !== e.exp_d) begin
                        n_bad++;
                        $display("FAIL %s: read=%h required=%h", e.nm, rdata, e.exp_d);
                    end
                end
                if (e.chk_i) begin
                    n_cmp++;
                    if (irq !== e.exp_i) begin
                        n_bad++;
                        $display("FAIL %s_irq: irq=%b required=%b", e.nm, irq, e.exp_i);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic w, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic cd, input logic [31:0] ed,
                       input logic ci, input logic ei, input string nm);
        we    = w;
        addr  = a;
        wdata = d;
        strb  = s;
        if (cd || ci) begin
            sb_q.push_back('{nm, cd, ed, ci, ei});
            mon_en = 1'b1;
        end else begin
            mon_en = 1'b0;
        end
        @(posedge clk);
        #1;
        mon_en = 1'b0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc(1'b1, a, d, s, 1'b0, 32'h0, 1'b0, 1'b0, "");
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] ex, input string nm);
        cyc(1'b0, a, 32'h0, 4'h0, 1'b1, ex, 1'b0, 1'b0, nm);
    endtask

    task automatic rdi(input logic [9:0] a, input logic [31:0] ex, input logic ei, input string nm);
        cyc(1'b0, a, 32'h0, 4'h0, 1'b1, ex, 1'b1, ei, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        we    = 1'b0;
        addr  = 10'h0;
        wdata = 32'h0;
        strb  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        rdi(A_CNT, 32'h0, 1'b0, "rst_count");
        rd(A_CMP, 32'hFFFF_FFFF, "rst_compare");
        rd(A_CTL, 32'h0, "rst_ctrl");
        rd(A_RSV, 32'h0, "rst_reserved");

        // byte-lane RAM writes
        wr(10'h010, 32'h1122_3344, 4'hF);
        cyc(1'b1, 10'h010, 32'hAABB_CCDD, 4'b0101, 1'b1, 32'h1122_3344, 1'b0, 1'b0, "t1_same_cycle_old");
        rd(10'h010, 32'h11BB_33DD, "t1_lane_merge");
        wr(10'h010, 32'hFFFF_FFFF, 4'h0);
        rd(10'h010, 32'h11BB_33DD, "t1_zero_strobe_noop");
        wr(10'h3EC, 32'hCAFE_F00D, 4'hF);
        rd(10'h3EC, 32'hCAFE_F00D, "t1_last_ram_word");
        wr(A_RSV, 32'hDEAD_BEEF, 4'hF);
        rd(A_RSV, 32'h0, "t1_reserved_after_write");

        // timer match and interrupt
        wr(A_CMP, 32'd5, 4'hF);
        wr(A_CNT, 32'd0, 4'hF);
        wr(A_CTL, 32'h5, 4'hF);
        for (int i = 0; i < 6; i++) rdi(A_CNT, 32'(i), 1'b0, "t2_count");
        rdi(A_CTL, 32'h105, 1'b1, "t2_match_set");
        rdi(A_CNT, 32'd7, 1'b1, "t2_keeps_counting");
        wr(A_CTL, 32'h105, 4'hF);
        rdi(A_CTL, 32'h5, 1'b0, "t2_match_cleared");

        // autoreload
        wr(A_CTL, 32'h0, 4'hF);
        wr(A_CMP, 32'd3, 4'hF);
        wr(A_CNT, 32'd0, 4'hF);
        wr(A_CTL, 32'h3, 4'hF);
        rd(A_CNT, 32'd0, "t3_seq0");
        rd(A_CNT, 32'd1, "t3_seq1");
        rd(A_CNT, 32'd2, "t3_seq2");
        rd(A_CNT, 32'd3, "t3_seq3");
        rd(A_CNT, 32'd0, "t3_seq_wrap0");
        rd(A_CNT, 32'd1, "t3_seq_wrap1");
        rdi(A_CTL, 32'h103, 1'b0, "t3_match_no_ie");

        // wrap and write priority
        wr(A_CTL, 32'h0, 4'hF);
        wr(A_CNT, 32'hFFFF_FFFF, 4'hF);
        wr(A_CTL, 32'h1, 4'hF);
        rd(A_CNT, 32'hFFFF_FFFF, "t4_pre_wrap");
        rd(A_CNT, 32'h0, "t4_wrap");
        wr(A_CNT, 32'h0000_1000, 4'hF);
        cyc(1'b1, A_CNT, 32'h0000_00AB, 4'b0001, 1'b1, 32'h0000_1000, 1'b0, 1'b0, "t4_before_lane_write");
        rd(A_CNT, 32'h0000_10AB, "t4_write_priority");

        // set vs clear collision
        wr(A_CTL, 32'h100, 4'hF);
        rd(A_CTL, 32'h0, "t5_cleared");
        wr(A_CNT, 32'd1, 4'hF);
        wr(A_CTL, 32'h5, 4'hF);
        rd(A_CNT, 32'd1, "t5_count1");
        rdi(A_CTL, 32'h5, 1'b0, "t5_pre_match");
        cyc(1'b1, A_CTL, 32'h105, 4'hF, 1'b1, 32'h5, 1'b1, 1'b0, "t5_collision_cycle");
        rdi(A_CTL, 32'h105, 1'b1, "t5_set_wins");

        // reset mid-operation with a concurrent RAM write
        wr(10'h020, 32'h5A5A_5A5A, 4'hF);
        rd(10'h020, 32'h5A5A_5A5A, "t6_ram_before");
        rst = 1'b1;
        wr(10'h020, 32'h1234_5678, 4'hF);
        rst = 1'b0;
        rdi(A_CNT, 32'h0, 1'b0, "t6_count");
        rd(A_CMP, 32'hFFFF_FFFF, "t6_compare");
        rd(A_CTL, 32'h0, "t6_ctrl");
        rd(10'h020, 32'h5A5A_5A5A, "t6_ram_unchanged");
        rd(A_RSV, 32'h0, "t6_reserved");

        @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: pending=%0d required=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder for the core's data-memory port: receives byte-addressed load/store requests and returns read data in the same cycle.
- Backs a word-organised RAM. The top 16 bytes of the address space are a memory-mapped timer register block.
- Produces a timer interrupt request for future trap support.
- Sits beside the core in the SoC top, wired directly to the core's data-memory outputs and input.

Parameters:
- MEM_ADDR_WIDTH, 10: byte address width. RAM depth is 2^(MEM_ADDR_WIDTH-2) words.
- DATA_WIDTH, 32: word width.
- TRANSFER_WIDTH, 4: byte-lane strobe width, equal to DATA_WIDTH/8.
- PERIPH_BASE, 10'h3F0: byte address of the timer block, 16-byte aligned.

Ports:
- clk  in  1: clock; all state updates on its rising edge.
- rst  in  1: reset, synchronous, active-high.
- we_mem_data_i  in  1: store request this cycle.
- addr_mem_data_i  in  MEM_ADDR_WIDTH: byte address.
- val_mem_data_write_i  in  DATA_WIDTH: store data, already lane-aligned.
- write_transfer_mem_data_i  in  TRANSFER_WIDTH: byte-lane write strobes.
- val_mem_data_read_o  out  DATA_WIDTH: load data, combinational.
- irq_timer_o  out  1: timer interrupt request, registered.

Behaviour:
- Word index is addr[MEM_ADDR_WIDTH-1:2]. addr[1:0] is ignored; lane alignment is the core's responsibility.
- Address decode: addr >= PERIPH_BASE selects the timer block; otherwise RAM.
  - RAM words shadowed by the timer block are unreachable.
- Reads: purely combinational from the current address. No read latency, because the core is single-cycle.
  - Writes are visible to reads from the next cycle.
  - A read of a location written in the same cycle returns the old value.
- RAM writes: on the clock edge when we=1 and the address decodes to RAM, each lane i with strobe[i]=1 is written. Lanes with strobe 0 are unchanged.
  - we=1 with strobes 4'b0000 is a no-op.
  - RAM is not reset; contents are undefined until written.
- Timer registers (offset from PERIPH_BASE):
  - 0x0 COUNT, RW.
  - 0x4 COMPARE, RW.
  - 0x8 CTRL:
    - bit0 EN, RW.
    - bit1 AUTORELOAD, RW.
    - bit2 IE, RW.
    - bit8 MATCH, read, write-1-to-clear.
    - Other bits read 0.
  - 0xC reserved: reads 0, writes ignored.
  - All timer writes honour byte strobes per lane.
- Reset values: COUNT=0, COMPARE=32'hFFFF_FFFF, CTRL=0, irq_timer_o=0.
  - When rst=1 on a clock edge, all write requests that cycle are dropped (RAM and registers).
- Counting, each edge with rst=0:
  - If a COUNT write is present: strobed lanes take the write data, unstrobed lanes hold their current value. No increment that cycle.
  - Otherwise, if EN=1 and COUNT==COMPARE and AUTORELOAD=1: COUNT <= 0.
  - Otherwise, if EN=1: COUNT <= COUNT+1, wrapping modulo 2^32 (32'hFFFF_FFFF -> 0).
  - Otherwise: hold.
- MATCH flag:
  - Set on the edge where EN=1 and COUNT==COMPARE, using pre-edge values.
  - Cleared by a CTRL write with strobe[1]=1 and data bit8=1.
  - If set and clear occur in the same cycle, set wins.
- irq_timer_o is registered: irq_timer_o <= next MATCH & next IE. It therefore asserts in the same cycle that MATCH reads 1.
- A COMPARE write changes the compare value from the next cycle; the match check in the write cycle uses the old COMPARE.

Test Plan:
1. Byte-lane RAM writes:
   - Stimulus: write 32'h11223344 to 0x010 with strobes 4'hF, then 32'hAABBCCDD to 0x010 with strobes 4'b0101.
   - Required: read of 0x010 returns 32'h11BB33DD. A read in the same cycle as the second write returns 32'h11223344.
2. Timer match and interrupt:
   - Stimulus: COMPARE=5, CTRL=32'h5 (EN, IE), COUNT=0.
   - Required: MATCH and irq_timer_o assert on the edge where COUNT advances 5->6. COUNT keeps counting.
   - Stimulus: CTRL write of 32'h105 with strobes 4'hF.
   - Required: MATCH and irq_timer_o both drop next cycle.
3. Autoreload:
   - Stimulus: COMPARE=3, CTRL=32'h3.
   - Required: COUNT sequence 0,1,2,3,0,1,... MATCH is set after the first wrap.
4. Wrap and write priority:
   - Stimulus: COUNT=32'hFFFF_FFFF with EN=1.
   - Required: next cycle COUNT=0.
   - Stimulus: COUNT write of 32'h0000_00AB with strobe 4'b0001 while EN=1 and COUNT=32'h0000_1000.
   - Required: next cycle COUNT=32'h0000_10AB, not incremented.
5. Set vs clear collision:
   - Stimulus: CTRL write clearing MATCH in the exact cycle COUNT==COMPARE with EN=1.
   - Required: MATCH remains 1.
6. Reset mid-operation:
   - Stimulus: rst=1 while EN=1, with a concurrent RAM write to 0x020.
   - Required: next cycle COUNT=0, COMPARE=32'hFFFF_FFFF, CTRL=0, irq_timer_o=0, and word 0x020 is unchanged.
   - Required: reserved offset 0xC reads 0 at all times.
